// File: rtl/busca_pkg.sv
// Shared definitions for the busca_maior frame-maximum finder.
package busca_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/arvore.sv
// 8-bit tree magnitude comparator: M = (a > b), I = (a == b).
// Per-bit greater/equal flags are merged pairwise, MSB half dominating.
module arvore
  import busca_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              M,
  output logic              I
);

  logic [7:0] g0, e0;
  logic [3:0] g1, e1;
  logic [1:0] g2, e2;

  always_comb begin
    g0 = a & ~b;
    e0 = ~(a ^ b);
    for (int k = 0; k < 4; k++) begin
      g1[k] = g0[2*k+1] | (e0[2*k+1] & g0[2*k]);
      e1[k] = e0[2*k+1] & e0[2*k];
    end
    for (int k = 0; k < 2; k++) begin
      g2[k] = g1[2*k+1] | (e1[2*k+1] & g1[2*k]);
      e2[k] = e1[2*k+1] & e1[2*k];
    end
    M = g2[1] | (e2[1] & g2[0]);
    I = e2[1] & e2[0];
  end

endmodule

// File: rtl/busca_maior.sv
// Streams a frame of bytes and reports its maximum, first index of the
// maximum, occurrence count, compared length and overflow flag.
module busca_maior
  import busca_pkg::*;
#(
  parameter int unsigned MAX_LEN = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_max,
  output logic [$clog2(MAX_LEN)-1:0]   out_idx,
  output logic [$clog2(MAX_LEN):0]     out_cnt,
  output logic [$clog2(MAX_LEN):0]     out_len,
  output logic                         out_ovf
);

  localparam int unsigned IDX_W = $clog2(MAX_LEN);
  localparam int unsigned CNT_W = IDX_W + 1;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic                ovf_q, ovf_d;

  logic accept;
  logic len_full;
  logic gt, eq;

  assign accept   = in_valid & in_ready;
  assign len_full = (len_q == CNT_W'(MAX_LEN));

  arvore u_arvore (
    .a (in_data),
    .b (max_q),
    .M (gt),
    .I (eq)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = in_last ? ST_DONE : ST_ACC;
      ST_ACC:  if (accept && in_last) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE, ST_ACC: in_ready  = 1'b1;
      ST_DONE:         out_valid = 1'b1;
      default:         ;
    endcase
  end

  // Beats past MAX_LEN are dropped and only mark overflow.
  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    len_d = len_q;
    ovf_d = ovf_q;
    if (accept) begin
      if (state_q == ST_IDLE) begin
        max_d = in_data;
        idx_d = '0;
        cnt_d = CNT_W'(1);
        len_d = CNT_W'(1);
        ovf_d = 1'b0;
      end else if (len_full) begin
        ovf_d = 1'b1;
      end else begin
        if (gt) begin
          max_d = in_data;
          idx_d = IDX_W'(len_q);
          cnt_d = CNT_W'(1);
        end else if (eq) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        len_d = len_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      max_q <= max_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_max = max_q;
  assign out_idx = idx_q;
  assign out_cnt = cnt_q;
  assign out_len = len_q;
  assign out_ovf = ovf_q;

endmodule

// File: tb/tb_busca_maior.sv
// Randomized self-checking bench for busca_maior (MAX_LEN 256 and 4 in parallel).
module tb_busca_maior;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic       in_ready, out_valid, out_ovf;
  logic [7:0] out_max, out_idx;
  logic [8:0] out_cnt, out_len;

  logic       in_ready4, out_valid4, out_ovf4;
  logic [7:0] out_max4;
  logic [1:0] out_idx4;
  logic [2:0] out_cnt4, out_len4;

  logic [7:0] ca, cb;
  logic       cm, ci;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] frame_q[$];

  always #5 clk = ~clk;

  busca_maior #(.MAX_LEN(256)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_max(out_max), .out_idx(out_idx),
    .out_cnt(out_cnt), .out_len(out_len), .out_ovf(out_ovf)
  );

  busca_maior #(.MAX_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid4),
    .out_ready(out_ready), .out_max(out_max4), .out_idx(out_idx4),
    .out_cnt(out_cnt4), .out_len(out_len4), .out_ovf(out_ovf4)
  );

  arvore u_cmp (.a(ca), .b(cb), .M(cm), .I(ci));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: first ml elements compared, ties keep the earliest index.
  task automatic model(input int ml, output int mx, output int ix,
                       output int ct, output int ln, output int ov);
    mx = 0; ix = 0; ct = 0; ln = 0;
    for (int i = 0; i < frame_q.size(); i++) begin
      if (i < ml) begin
        if (i == 0 || int'(frame_q[i]) > mx) begin
          mx = int'(frame_q[i]); ix = i; ct = 1;
        end else if (int'(frame_q[i]) == mx) begin
          ct++;
        end
        ln++;
      end
    end
    ov = (frame_q.size() > ml) ? 1 : 0;
  endtask

  task automatic chk_results(input string tag);
    int mx, ix, ct, ln, ov;
    model(256, mx, ix, ct, ln, ov);
    chk({tag, " max"}, 32'(out_max), 32'(mx));
    chk({tag, " idx"}, 32'(out_idx), 32'(ix));
    chk({tag, " cnt"}, 32'(out_cnt), 32'(ct));
    chk({tag, " len"}, 32'(out_len), 32'(ln));
    chk({tag, " ovf"}, 32'(out_ovf), 32'(ov));
    model(4, mx, ix, ct, ln, ov);
    chk({tag, " max4"}, 32'(out_max4), 32'(mx));
    chk({tag, " idx4"}, 32'(out_idx4), 32'(ix));
    chk({tag, " cnt4"}, 32'(out_cnt4), 32'(ct));
    chk({tag, " len4"}, 32'(out_len4), 32'(ln));
    chk({tag, " ovf4"}, 32'(out_ovf4), 32'(ov));
  endtask

  // Sends frame_q with random idle gaps, holds the result, then hands it off.
  task automatic run_frame(input string tag, input int gap_max, input int hold);
    int n;
    int gaps;
    n = frame_q.size();
    for (int i = 0; i < n; i++) begin
      gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (gaps) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = frame_q[i];
      in_last  = (i == n - 1);
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, " out_valid_busy"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " out_valid4"}, 32'(out_valid4), 32'd1);
    chk_results(tag);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, " hold valid"}, 32'(out_valid), 32'd1);
      chk({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, " hold in_ready4"}, 32'(in_ready4), 32'd0);
      chk_results({tag, " hold"});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " handoff valid"}, 32'(out_valid), 32'd0);
    chk({tag, " handoff in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] a8, b8;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    ca = '0; cb = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset max", 32'(out_max), 32'd0);
    chk("reset len", 32'(out_len), 32'd0);
    chk("reset ovf", 32'(out_ovf), 32'd0);

    // Comparator sweep over every operand pair.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        ca = 8'(a); cb = 8'(b);
        #1;
        chk("arvore", {30'd0, cm, ci}, {30'd0, (a > b), (a == b)});
      end
    end
    @(posedge clk); #1;

    frame_q = '{8'd3, 8'd9, 8'd5, 8'd9};
    run_frame("f3959", 0, 0);
    frame_q = '{8'hA5};
    run_frame("single", 0, 0);
    frame_q = '{8'hFF, 8'h00, 8'hFF, 8'hFE};
    run_frame("gaps_hold", 2, 5);
    frame_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd200};
    run_frame("ovf4", 0, 0);

    // Partial frame discarded by reset.
    in_valid = 1'b1; in_data = 8'd50; in_last = 1'b0;
    @(posedge clk); #1;
    in_data = 8'd60;
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("rst mid out_valid", 32'(out_valid), 32'd0);
    chk("rst mid in_ready", 32'(in_ready), 32'd1);
    chk("rst mid max", 32'(out_max), 32'd0);
    chk("rst mid len", 32'(out_len), 32'd0);
    chk("rst mid cnt", 32'(out_cnt), 32'd0);
    frame_q = '{8'd7, 8'd7};
    run_frame("after_rst", 0, 0);

    // Frame longer than 256 elements.
    frame_q = {};
    for (int i = 0; i < 258; i++) frame_q.push_back(8'($urandom_range(255, 0)));
    run_frame("long", 0, 0);

    // Random frames of varied length, including equal-value heavy ones.
    for (int f = 0; f < 200; f++) begin
      frame_q = {};
      for (int i = 0; i < int'($urandom_range(9, 1)); i++)
        frame_q.push_back(8'($urandom_range(7, 0)) << ($urandom_range(1, 0) * 5));
      run_frame("rand", 1, int'($urandom_range(2, 0)));
    end

    // Back-to-back two-element frames: corners then random pairs.
    for (int p = 0; p < 1500; p++) begin
      a8 = 8'($urandom_range(255, 0));
      b8 = (p % 4 == 0) ? a8 : 8'($urandom_range(255, 0));
      if (p == 0) begin a8 = 8'h00; b8 = 8'hFF; end
      if (p == 1) begin a8 = 8'hFF; b8 = 8'h00; end
      if (p == 2) begin a8 = 8'hFF; b8 = 8'hFF; end
      if (p == 3) begin a8 = 8'h00; b8 = 8'h00; end
      frame_q = '{a8, b8};
      run_frame("pair", 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
